mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multiply/divide unit with its own sequencer for the E stage of the five-stage MIPS pipeline. Accepts mult/multu/div/divu/mthi/mtlo from E and computes results into the architectural HI/LO registers over a fixed multi-cycle latency. Drives `busy` for mfhi/mflo forwarding. Generates the D-stage stall request that holds any HI/LO-touching instruction in D while an operation is in flight.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  E-stage instruction is an MDU op this cycle; one-cycle pulse per instruction.
- `md_op`  in  3  operation code, valid when `start`=1.
- `rs_data`  in  32  forwarded rs operand from E.
- `rt_data`  in  32  forwarded rt operand from E.
- `md_instr_D`  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `hi`  out  32  architectural HI; reset 0.
- `lo`  out  32  architectural LO; reset 0.
- `busy`  out  1  operation in flight; reset 0.
- `stall_md`  out  1  stall request to the D-stage hazard unit; combinational; 0 during reset.

## Operation
- Two-state FSM:
  - IDLE: `busy`=0.
  - BUSY: `busy`=1, 4-bit down-counter `cnt`.
- IDLE with `start`=1:
  - MULT/MULTU: compute the 64-bit product. Signed for MULT, unsigned for MULTU. Latch {hi_p, lo_p}. Load `cnt`=MULT_CYCLES. Go to BUSY.
  - DIV/DIVU: lo_p = quotient, hi_p = remainder. Signed DIV truncates toward zero; remainder takes the dividend's sign. Load `cnt`=DIV_CYCLES. Go to BUSY.
  - DIV with 0x80000000 / 0xFFFFFFFF: lo_p=0x80000000, hi_p=0.
  - Divide by zero (`rt_data`=0): goes BUSY for DIV_CYCLES as usual. HI/LO are left unchanged at commit (commit suppressed).
  - MTHI: `hi` <= `rs_data` at this edge; stays IDLE.
  - MTLO: `lo` <= `rs_data` at this edge; stays IDLE.
  - MD_NONE: no effect.
- BUSY:
  - `cnt` decrements each cycle.
  - When `cnt`=1: `hi`<=hi_p and `lo`<=lo_p (unless commit suppressed), then go to IDLE.
- `start`=1 while BUSY is illegal and ignored; `stall_md` guarantees it never occurs.
- `stall_md` = `md_instr_D` & (`busy` | (`start` & md_op in {MULT,MULTU,DIV,DIVU})).
- `hi`/`lo` outputs come straight from the registers; mfhi/mflo read them in E.

## Timing
- `start` sampled at edge e0 (end of cycle k):
  - `busy`=1 in cycles k+1..k+N, where N = MULT_CYCLES or DIV_CYCLES.
  - New `hi`/`lo` visible from cycle k+N+1; `busy`=0 in the same cycle.
- MTHI/MTLO: new value visible in cycle k+1, zero busy cycles.
- Back-to-back: a new `start` is legal in cycle k+N+1.
- `stall_md` is high in cycle k (start cycle) and k+1..k+N. It drops in cycle k+N+1, so an mfhi held in D enters E seeing the committed value.
- Reset asserted mid-operation:
  - Pending result discarded.
  - `hi`=`lo`=0, `busy`=0, FSM=IDLE.
  - All take effect asynchronously, without waiting for `clk`.
- N=1 is legal: `busy` is high for exactly one cycle.

## Structure
- Package `mdu_pkg`:
  - `md_op` encoding: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
  - FSM state type {S_IDLE, S_BUSY}.
  - Default cycle constants.
- Sub-module `mdu_arith`: purely combinational. Inputs: op, rs, rt. Outputs: 64-bit {hi_p, lo_p} and `div_zero`.
- `mdu_ctrl` holds the FSM, counter, pending registers, HI/LO and stall logic.

## Test plan
- MULT, rs=0xFFFFFFFD (-3), rt=5: `busy` high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU, rs=0xFFFFFFFF, rt=2: hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- DIV, rs=0xFFFFFFF9 (-7), rt=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles.
- DIVU rs=7, rt=0, with hi/lo preset to 0x11/0x22 via MTHI/MTLO: 10 busy cycles, hi/lo remain 0x11/0x22.
- MULT start with `md_instr_D`=1 held (mfhi behind it): `stall_md` high in the start cycle plus 5 busy cycles, low on the cycle `hi` updates.
- Reset pulse at busy cycle 4 of a DIV: `busy`, `hi`, `lo` go to 0 immediately. No commit after reset release. A subsequent MTLO of 0x5 reads back lo=0x5 next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Op encoding, FSM state type, default latencies, and an op-class helper.
// No logic of its own.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Ops that occupy the unit for multiple cycles (as opposed to MTHI/MTLO).
    function automatic logic is_long_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: produces {hi, lo} for one MDU op.
// Latency: zero (purely combinational); the sequencer supplies the cycle count.
// Ports: op/rs/rt in; res = {hi_p, lo_p} and div_zero out. No backpressure.
module mdu_arith
    import mdu_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [63:0] res,
    output logic        div_zero
);

    logic [63:0] mul_a, mul_b, prod;
    logic        sgn_div;
    logic [31:0] a_abs, b_abs, divisor, q_u, r_u, q, r;

    always_comb begin
        // Sign- or zero-extend to 64 bits; the truncated 64-bit product is then
        // exact for both signed and unsigned operands.
        mul_a = (op == MD_MULT) ? {{32{rs[31]}}, rs} : {32'd0, rs};
        mul_b = (op == MD_MULT) ? {{32{rt[31]}}, rt} : {32'd0, rt};
        prod  = mul_a * mul_b;

        // Signed divide via magnitudes. 0x80000000 / -1 falls out naturally:
        // magnitude quotient 0x80000000 negates back to 0x80000000, remainder 0.
        sgn_div  = (op == MD_DIV);
        div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (rt == 32'd0);
        a_abs    = (sgn_div && rs[31]) ? (32'd0 - rs) : rs;
        b_abs    = (sgn_div && rt[31]) ? (32'd0 - rt) : rt;
        // Keep the divider defined on zero; the result is discarded anyway.
        divisor  = (rt == 32'd0) ? 32'd1 : b_abs;
        q_u      = a_abs / divisor;
        r_u      = a_abs % divisor;
        q        = (sgn_div && (rs[31] ^ rt[31])) ? (32'd0 - q_u) : q_u;
        r        = (sgn_div && rs[31]) ? (32'd0 - r_u) : r_u;

        res = 64'd0;
        case (op)
            MD_MULT, MD_MULTU: res = prod;
            MD_DIV, MD_DIVU:   res = {r, q};
            default:           res = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer for E: latches the op result, holds busy for a fixed count, commits to HI/LO.
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles for mult/div; MTHI/MTLO write in one edge.
// Backpressure: stall_md holds HI/LO-touching instructions in D while an op is in flight.
// Ports: clk, reset (async high), start/md_op/rs_data/rt_data from E, md_instr_D from D;
//        hi/lo architectural registers, busy, stall_md (combinational).
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        md_instr_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

    md_op_e      op;
    mdu_state_e  state, state_nxt;
    logic [3:0]  cnt;
    logic [31:0] hi_p, lo_p;
    logic        suppress;
    logic [63:0] arith_res;
    logic        arith_div_zero;
    logic        launch;

    assign op = md_op_e'(md_op);

    mdu_arith u_arith (
        .op       (op),
        .rs       (rs_data),
        .rt       (rt_data),
        .res      (arith_res),
        .div_zero (arith_div_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            S_IDLE: begin
                launch = start && is_long_op(op);
                if (launch) state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (cnt == 4'd1) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= 4'd0;
            hi_p     <= 32'd0;
            lo_p     <= 32'd0;
            suppress <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else if (state == S_IDLE) begin
            if (launch) begin
                hi_p     <= arith_res[63:32];
                lo_p     <= arith_res[31:0];
                suppress <= arith_div_zero;
                cnt      <= ((op == MD_MULT) || (op == MD_MULTU)) ? MULT_LD : DIV_LD;
            end else if (start && (op == MD_MTHI)) begin
                hi <= rs_data;
            end else if (start && (op == MD_MTLO)) begin
                lo <= rs_data;
            end
        end else begin
            // A start arriving here is illegal (stall_md prevents it) and is ignored.
            cnt <= cnt - 4'd1;
            if ((cnt == 4'd1) && !suppress) begin
                hi <= hi_p;
                lo <= lo_p;
            end
        end
    end

    assign busy = (state == S_BUSY);

    // Includes the launch cycle itself so a following mfhi/mflo in D never
    // slips into E before the result commits. Forced low while in reset.
    assign stall_md = !reset && md_instr_D && (busy || (start && is_long_op(op)));

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data, rt_data;
    logic        md_instr_D;
    logic [31:0] hi, lo;
    logic        busy, stall_md;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .md_op      (md_op),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .md_instr_D (md_instr_D),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .stall_md   (stall_md)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          exp_cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op at a negedge, then count busy cycles (bounded) until idle.
    // Returns at the negedge of the first non-busy cycle after the op.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         output int cycles);
        @(negedge clk);
        start   = 1'b1;
        md_op   = op;
        rs_data = rs;
        rt_data = rt;
        @(negedge clk);
        start   = 1'b0;
        md_op   = MD_NONE;
        cycles  = 0;
        while (busy && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        int stall_cnt;

        vecs[0]  = '{MD_MULT,  32'hFFFF_FFFD, 32'd5,        5,  32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'd2,        5,  32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{MD_DIVU,  32'd100,       32'd7,        10, 32'h0000_0002, 32'h0000_000E};
        vecs[5]  = '{MD_MTHI,  32'h0000_0011, 32'd0,        0,  32'h0000_0011, 32'h0000_000E};
        vecs[6]  = '{MD_MTLO,  32'h0000_0022, 32'd0,        0,  32'h0000_0011, 32'h0000_0022};
        vecs[7]  = '{MD_DIVU,  32'd7,         32'd0,        10, 32'h0000_0011, 32'h0000_0022};
        vecs[8]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{MD_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 5, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[10] = '{MD_NONE,  32'h1234_5678, 32'h9ABC_DEF0, 0, 32'h3FFF_FFFF, 32'h0000_0001};

        // Reset state, with stall conditions on the inputs to show it is gated.
        reset      = 1'b1;
        start      = 1'b1;
        md_op      = MD_MULT;
        rs_data    = 32'd0;
        rt_data    = 32'd0;
        md_instr_D = 1'b1;
        #12;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_stall", {31'd0, stall_md}, 32'd0);
        start      = 1'b0;
        md_op      = MD_NONE;
        md_instr_D = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt, cyc);
            check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
            check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
        end

        // Stall: MULT with an mfhi waiting in D.
        @(negedge clk);
        md_instr_D = 1'b1;
        start      = 1'b1;
        md_op      = MD_MULT;
        rs_data    = 32'd3;
        rt_data    = 32'd4;
        #1;
        check("stall_start_cycle", {31'd0, stall_md}, 32'd1);
        @(negedge clk);
        start     = 1'b0;
        md_op     = MD_NONE;
        stall_cnt = 0;
        while (stall_md && stall_cnt < 40) begin
            stall_cnt++;
            @(negedge clk);
        end
        check("stall_busy_cycles", 32'(stall_cnt), 32'd5);
        check("stall_drop_busy", {31'd0, busy}, 32'd0);
        check("stall_drop_hi", hi, 32'd0);
        check("stall_drop_lo", lo, 32'd12);
        md_instr_D = 1'b0;

        // Reset mid-DIV at busy cycle 4.
        @(negedge clk);
        start   = 1'b1;
        md_op   = MD_DIV;
        rs_data = 32'd100;
        rt_data = 32'd3;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        repeat (3) @(negedge clk);
        check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        check("rst_async_hi", hi, 32'd0);
        check("rst_async_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_no_commit_busy", {31'd0, busy}, 32'd0);
        check("rst_no_commit_hi", hi, 32'd0);
        check("rst_no_commit_lo", lo, 32'd0);
        issue(MD_MTLO, 32'h5, 32'd0, cyc);
        check("post_rst_mtlo_lo", lo, 32'h5);
        check("post_rst_mtlo_cycles", 32'(cyc), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
